// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty sequencer and datapath decoder:
// controller states, instruction format codes and instruction field positions.
package bitty_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    STORE = 3'd3,
    TRAP  = 3'd4
  } state_t;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;

  localparam int INSTR_W     = 16;
  localparam int INSTR_MSB   = 15;
  localparam int IMM_LSB     = 7;
  localparam int IMM_SPAN    = INSTR_MSB - IMM_LSB + 1;
  localparam int ALU_MSB     = 6;
  localparam int ALU_LSB     = 3;
  localparam int ALU_FIELD_W = ALU_MSB - ALU_LSB + 1;
  localparam int MODE_BIT    = 2;
  localparam int FMT_MSB     = 1;
  localparam int FMT_LSB     = 0;

  // Only R-type and I-type words are executable; the other two codes trap.
  function automatic logic fmt_legal(input logic [1:0] fmt);
    return (fmt == FMT_R) || (fmt == FMT_I);
  endfunction

endpackage

// File: rtl/bitty_instr_decode.sv
// Combinational field extraction for a bitty instruction word. Register index
// width follows the register count, so the immediate grows as registers shrink.
module bitty_instr_decode
  import bitty_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int IDX_W = $clog2(NUM_REGS),
  localparam int IMM_W = IMM_SPAN - IDX_W
) (
  input  logic [INSTR_W-1:0]     ir,
  output logic [IDX_W-1:0]       rx,
  output logic [IDX_W-1:0]       ry,
  output logic [IMM_W-1:0]       imm,
  output logic [ALU_FIELD_W-1:0] alu,
  output logic                   mode,
  output logic                   is_imm,
  output logic                   legal
);

  assign rx     = ir[INSTR_MSB -: IDX_W];
  assign ry     = ir[INSTR_MSB-IDX_W -: IDX_W];
  assign imm    = ir[INSTR_MSB-IDX_W : IMM_LSB];
  assign alu    = ir[ALU_MSB:ALU_LSB];
  assign mode   = ir[MODE_BIT];
  assign is_imm = (ir[FMT_MSB:FMT_LSB] == FMT_I);
  assign legal  = fmt_legal(ir[FMT_MSB:FMT_LSB]);

endmodule

// File: rtl/bitty_ctrl_fsm.sv
// bitty sequencer: accepts instructions over valid/ready, latches them into an
// instruction register and steps each through LOAD/CALC/STORE, or TRAP for an
// illegal format. Outputs depend only on state, IR and run.
module bitty_ctrl_fsm
  import bitty_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int ALU_SEL_W = 4,
  parameter int CNT_W     = 16,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int IMM_W     = IMM_SPAN - IDX_W,
  localparam int MUX_SEL_W = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [15:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [MUX_SEL_W-1:0] mux_sel,
  output logic [15:0]          imm_out,
  output logic                 en_s,
  output logic                 en_c,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 mode,
  output logic [NUM_REGS-1:0]  reg_en,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  state_t                 state;
  state_t                 next_state;
  logic [INSTR_W-1:0]     ir;
  logic                   transfer;
  logic                   instr_legal;

  logic [IDX_W-1:0]       dec_rx;
  logic [IDX_W-1:0]       dec_ry;
  logic [IMM_W-1:0]       dec_imm;
  logic [ALU_FIELD_W-1:0] dec_alu;
  logic                   dec_mode;
  logic                   dec_is_imm;
  logic                   dec_legal;

  bitty_instr_decode #(
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .ir     (ir),
    .rx     (dec_rx),
    .ry     (dec_ry),
    .imm    (dec_imm),
    .alu    (dec_alu),
    .mode   (dec_mode),
    .is_imm (dec_is_imm),
    .legal  (dec_legal)
  );

  // Ready is held low while reset is asserted so nothing looks acceptable mid-reset.
  assign instr_ready = run & ~reset & ((state == IDLE) | (state == STORE));
  assign transfer    = instr_valid & instr_ready;
  assign instr_legal = fmt_legal(instr[FMT_MSB:FMT_LSB]);
  assign imm_out     = 16'(dec_imm);

  // State register: frozen whenever run is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (run) begin
      state <= next_state;
    end
  end

  // Instruction register loads only on an accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (transfer) begin
      ir <= instr;
    end
  end

  // Retired counter advances once per completed STORE and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (run && (state == STORE)) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Next-state logic; STORE may accept the following instruction directly.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          next_state = instr_legal ? LOAD : TRAP;
        end
      end
      LOAD:  next_state = CALC;
      CALC:  next_state = STORE;
      STORE: begin
        if (transfer) begin
          next_state = instr_legal ? LOAD : TRAP;
        end else begin
          next_state = IDLE;
        end
      end
      TRAP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe decode from state and IR; run low forces everything quiet.
  always_comb begin
    mux_sel = '0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    alu_sel = '0;
    mode    = 1'b0;
    reg_en  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    if (run) begin
      case (state)
        LOAD: begin
          mux_sel = MUX_SEL_W'(dec_rx);
          en_s    = 1'b1;
        end
        CALC: begin
          en_c    = 1'b1;
          alu_sel = ALU_SEL_W'(dec_alu);
          mode    = dec_mode;
          mux_sel = dec_is_imm ? MUX_SEL_W'(NUM_REGS) : MUX_SEL_W'(dec_ry);
        end
        STORE: begin
          reg_en[dec_rx] = dec_legal;
          done           = 1'b1;
        end
        TRAP: begin
          illegal = 1'b1;
          done    = 1'b1;
        end
        default: begin
          mux_sel = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_ctrl_fsm.sv
// Self-checking bench for bitty_ctrl_fsm. A cycle-level model tracks the
// in-flight instruction by its age since acceptance and predicts every output;
// directed sequences add hand-computed literal expectations.
module tb_bitty_ctrl_fsm;

  localparam int NUM_REGS  = 8;
  localparam int ALU_SEL_W = 4;
  localparam int CNT_W     = 16;
  localparam int MUX_SEL_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run;
  logic [15:0]          instr;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [MUX_SEL_W-1:0] mux_sel;
  logic [15:0]          imm_out;
  logic                 en_s;
  logic                 en_c;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 mode;
  logic [NUM_REGS-1:0]  reg_en;
  logic                 done;
  logic                 illegal;
  logic [CNT_W-1:0]     retired;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int done_cycles[$];

  // Model: whether an instruction is in flight, its age and the last accepted word.
  bit          m_have;
  int          m_age;
  logic [15:0] m_ir;
  int          m_retired;
  bit          m_legal;
  bit          m_rdy;

  bitty_ctrl_fsm #(
    .NUM_REGS  (NUM_REGS),
    .ALU_SEL_W (ALU_SEL_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mux_sel     (mux_sel),
    .imm_out     (imm_out),
    .en_s        (en_s),
    .en_c        (en_c),
    .alu_sel     (alu_sel),
    .mode        (mode),
    .reg_en      (reg_en),
    .done        (done),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [15:0] w);
    return (int'(w) % 4) < 2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic r);
    instr_valid = v;
    instr       = w;
    run         = r;
  endtask

  // Predict every output from the model and compare against the DUT.
  task automatic compareAll();
    int e_mux, e_alu, e_regen, e_imm;
    bit e_ready, e_en_s, e_en_c, e_mode, e_done, e_illegal;
    int rx, ry;
    e_mux = 0; e_alu = 0; e_regen = 0;
    e_en_s = 0; e_en_c = 0; e_mode = 0; e_done = 0; e_illegal = 0;
    e_imm = (int'(m_ir) / 128) % 64;
    rx = int'(m_ir) / 8192;
    ry = (int'(m_ir) / 1024) % 8;
    e_ready = run && !reset && (!m_have || (is_legal(m_ir) && m_age == 3));
    if (run && m_have) begin
      if (is_legal(m_ir)) begin
        if (m_age == 1) begin
          e_mux  = rx;
          e_en_s = 1;
        end else if (m_age == 2) begin
          e_en_c = 1;
          e_alu  = (int'(m_ir) / 8) % 16;
          e_mode = m_ir[2];
          e_mux  = ((int'(m_ir) % 4) == 1) ? NUM_REGS : ry;
        end else if (m_age == 3) begin
          e_regen = 1 << rx;
          e_done  = 1;
        end
      end else begin
        e_illegal = 1;
        e_done    = 1;
      end
    end
    checkOutput("instr_ready", instr_ready, e_ready);
    checkOutput("mux_sel",     mux_sel,     e_mux);
    checkOutput("imm_out",     imm_out,     e_imm);
    checkOutput("en_s",        en_s,        e_en_s);
    checkOutput("en_c",        en_c,        e_en_c);
    checkOutput("alu_sel",     alu_sel,     e_alu);
    checkOutput("mode",        mode,        e_mode);
    checkOutput("reg_en",      reg_en,      e_regen);
    checkOutput("done",        done,        e_done);
    checkOutput("illegal",     illegal,     e_illegal);
    checkOutput("retired",     retired,     m_retired);
    if (done === 1'b1) done_cycles.push_back(cycle);
  endtask

  // Advance the model at each clock edge, then compare mid-way through the high phase.
  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      m_have = 0; m_age = 0; m_ir = '0; m_retired = 0;
    end else if (run) begin
      m_legal = is_legal(m_ir);
      m_rdy   = !m_have || (m_legal && m_age == 3);
      if (m_have) begin
        if ((m_legal && m_age == 3) || (!m_legal && m_age == 1)) begin
          m_have = 0;
          if (m_legal) m_retired = (m_retired + 1) % 65536;
        end else begin
          m_age++;
        end
      end
      if (instr_valid && m_rdy) begin
        m_have = 1; m_age = 1; m_ir = instr;
      end
    end
    #4;
    compareAll();
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_done;
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("reset_ready",   instr_ready, 0);
    checkOutput("reset_retired", retired,     0);
    checkOutput("reset_imm",     imm_out,     0);
    reset = 1'b0;
    #1 checkOutput("ready_after_reset", instr_ready, 1);

    // R-type 0x2818: rx=1, ry=2, alu=3
    @(negedge clk) applyStimulus(1'b1, 16'h2818, 1'b1);
    @(negedge clk);
    checkOutput("r_load_mux", mux_sel, 1);
    checkOutput("r_load_en_s", en_s, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("r_calc_mux", mux_sel, 2);
    checkOutput("r_calc_en_c", en_c, 1);
    checkOutput("r_calc_alu", alu_sel, 3);
    checkOutput("r_calc_mode", mode, 0);
    @(negedge clk);
    checkOutput("r_store_reg_en", reg_en, 32'h02);
    checkOutput("r_store_done", done, 1);
    @(negedge clk);
    checkOutput("r_retired", retired, 1);
    checkOutput("r_idle_ready", instr_ready, 1);

    // I-type 0x752D: rx=3, imm=0x2A, alu=5, mode=1
    applyStimulus(1'b1, 16'h752D, 1'b1);
    @(negedge clk);
    checkOutput("i_imm_out", imm_out, 32'h2A);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("i_calc_mux", mux_sel, 8);
    checkOutput("i_calc_mode", mode, 1);
    checkOutput("i_calc_alu", alu_sel, 5);
    @(negedge clk);
    checkOutput("i_store_reg_en", reg_en, 32'h08);
    @(negedge clk);
    checkOutput("i_retired", retired, 2);

    // Illegal format 0x0002
    applyStimulus(1'b1, 16'h0002, 1'b1);
    @(negedge clk);
    checkOutput("trap_illegal", illegal, 1);
    checkOutput("trap_done", done, 1);
    checkOutput("trap_reg_en", reg_en, 0);
    checkOutput("trap_ready", instr_ready, 0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("post_trap_ready", instr_ready, 1);
    checkOutput("post_trap_retired", retired, 2);

    // Back-to-back issue: second word accepted during the first STORE
    n_done = done_cycles.size();
    applyStimulus(1'b1, 16'h2818, 1'b1);
    @(negedge clk) applyStimulus(1'b1, 16'h752D, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_store_ready", instr_ready, 1);
    @(negedge clk);
    checkOutput("b2b_second_load", en_s, 1);
    checkOutput("b2b_second_mux", mux_sel, 3);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("b2b_retired", retired, 4);
    checkOutput("b2b_done_count", done_cycles.size() - n_done, 2);
    if (done_cycles.size() - n_done == 2)
      checkOutput("b2b_done_spacing",
                  done_cycles[done_cycles.size()-1] - done_cycles[done_cycles.size()-2], 3);

    // run low for five cycles while in CALC
    applyStimulus(1'b1, 16'h752D, 1'b1);
    @(negedge clk) applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("freeze_pre_en_c", en_c, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("freeze_en_c", en_c, 0);
      checkOutput("freeze_alu", alu_sel, 0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    #1;
    checkOutput("resume_en_c", en_c, 1);
    checkOutput("resume_alu", alu_sel, 5);
    @(negedge clk);
    checkOutput("resume_store_reg_en", reg_en, 32'h08);
    @(negedge clk);
    checkOutput("resume_retired", retired, 5);

    // run low in IDLE blocks acceptance
    applyStimulus(1'b1, 16'h0003, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("run0_ready", instr_ready, 0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("run0_no_trap", illegal, 0);

    // Asynchronous reset during CALC discards the instruction
    applyStimulus(1'b1, 16'h2818, 1'b1);
    @(negedge clk) applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("pre_reset_en_c", en_c, 1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_en_c", en_c, 0);
    checkOutput("async_reset_ready", instr_ready, 0);
    checkOutput("async_reset_retired", retired, 0);
    checkOutput("async_reset_imm", imm_out, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("release_ready", instr_ready, 1);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_retired", retired, 0);
    checkOutput("post_reset_reg_en", reg_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
